// File: rtl/alu_sequencer.sv
// alu_sequencer: expands (op, operand, last) commands into alu opcode/data_in streams and returns OUT results
module alu_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int OUT_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  a_reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_operand,
  input  logic                  cmd_last,
  output logic [3:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_data_in,
  input  logic [DATA_WIDTH-1:0] alu_data_out,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [DATA_WIDTH-1:0] result_data,
  output logic [7:0]            result_count,
  output logic                  err_illegal
);
  localparam logic [3:0] NOP = 4'd0, REGA = 4'd1, OUTC = 4'd7, RST = 4'd8;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_OUT, S_WAIT, S_HOLD, S_CLR} state_t;
  state_t                r_state, w_state;
  logic [2:0]            r_op, w_op;
  logic                  r_last, w_last;
  logic [7:0]            r_cnt, w_cnt;
  logic [2:0]            r_wait, w_wait;
  logic                  r_cmd_ready, w_cmd_ready;
  logic [3:0]            r_opcode, w_opcode;
  logic [DATA_WIDTH-1:0] r_din, w_din;
  logic                  r_rvalid, w_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata;
  logic [7:0]            r_rcount, w_rcount;
  logic                  r_err, w_err;
  logic                  w_accept;
  assign w_accept = cmd_valid && r_cmd_ready;
  // Every output is computed one cycle ahead so the state and its outputs line up
  always_comb begin
    w_state  = r_state;
    w_op     = r_op;
    w_last   = r_last;
    w_cnt    = r_cnt;
    w_wait   = r_wait;
    w_opcode = NOP;
    w_din    = r_din;
    w_rvalid = r_rvalid;
    w_rdata  = r_rdata;
    w_rcount = r_rcount;
    w_err    = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_op   = cmd_op;
        w_last = cmd_last;
        if (cmd_op == 3'd0) begin
          w_state  = S_CLR;
          w_opcode = RST;
          w_cnt    = 8'd0;
        end else if (cmd_op > 3'd5) begin
          w_err = 1'b1;
        end else begin
          w_state  = S_LOAD;
          w_opcode = REGA;
          w_din    = cmd_operand;
        end
      end
      S_LOAD: begin
        w_state  = S_EXEC;
        w_opcode = {1'b0, r_op} + 4'd1;
        w_cnt    = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
      end
      S_EXEC: begin
        w_state  = r_last ? S_OUT : S_IDLE;
        w_opcode = r_last ? OUTC : NOP;
        w_wait   = 3'(OUT_LATENCY - 1);
      end
      S_OUT: w_state = S_WAIT;
      S_WAIT: if (r_wait == 3'd0) begin
        w_state  = S_HOLD;
        w_rvalid = 1'b1;
        w_rdata  = alu_data_out;
        w_rcount = r_cnt;
        w_cnt    = 8'd0;
      end else begin
        w_wait = r_wait - 3'd1;
      end
      S_HOLD: if (result_ready) begin
        w_state  = S_IDLE;
        w_rvalid = 1'b0;
      end
      S_CLR: w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
    w_cmd_ready = (w_state == S_IDLE) && !w_rvalid;
  end
  always_ff @(posedge clk) begin
    if (!a_reset_n) begin
      r_state     <= S_IDLE;
      r_op        <= 3'd0;
      r_last      <= 1'b0;
      r_cnt       <= 8'd0;
      r_wait      <= 3'd0;
      r_cmd_ready <= 1'b0;
      r_opcode    <= NOP;
      r_din       <= '0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_rcount    <= 8'd0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_op        <= w_op;
      r_last      <= w_last;
      r_cnt       <= w_cnt;
      r_wait      <= w_wait;
      r_cmd_ready <= w_cmd_ready;
      r_opcode    <= w_opcode;
      r_din       <= w_din;
      r_rvalid    <= w_rvalid;
      r_rdata     <= w_rdata;
      r_rcount    <= w_rcount;
      r_err       <= w_err;
    end
  end
  assign cmd_ready    = r_cmd_ready;
  assign alu_opcode   = r_opcode;
  assign alu_data_in  = r_din;
  assign result_valid = r_rvalid;
  assign result_data  = r_rdata;
  assign result_count = r_rcount;
  assign err_illegal  = r_err;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: two sequencers (OUT_LATENCY 1 and 3) driving behavioural alu models, checked against a command-level model
module tb_alu_sequencer;
  logic       clk = 1'b0;
  logic       rst_n        [2];
  logic       cmd_valid    [2];
  logic       cmd_ready    [2];
  logic [2:0] cmd_op       [2];
  logic [7:0] cmd_operand  [2];
  logic       cmd_last     [2];
  logic [3:0] alu_opcode   [2];
  logic [7:0] alu_data_in  [2];
  logic [7:0] alu_data_out [2];
  logic       result_valid [2];
  logic       result_ready [2];
  logic [7:0] result_data  [2];
  logic [7:0] result_count [2];
  logic       err_illegal  [2];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] m_acc [2];
  logic [7:0] m_din [2];
  logic [7:0] m_res [2];
  int         m_cnt [2];
  int         m_rc  [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int L = (g == 0) ? 1 : 3;
    logic [7:0] acc = 8'h00;
    logic [7:0] ra = 8'h00;
    logic [7:0] p [3] = '{8'h00, 8'h00, 8'h00};
    alu_sequencer #(.DATA_WIDTH(8), .OUT_LATENCY(L)) u_dut (
      .clk(clk), .a_reset_n(rst_n[g]), .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
      .cmd_op(cmd_op[g]), .cmd_operand(cmd_operand[g]), .cmd_last(cmd_last[g]),
      .alu_opcode(alu_opcode[g]), .alu_data_in(alu_data_in[g]), .alu_data_out(alu_data_out[g]),
      .result_valid(result_valid[g]), .result_ready(result_ready[g]), .result_data(result_data[g]),
      .result_count(result_count[g]), .err_illegal(err_illegal[g])
    );
    // alu: accumulator with register A; OUT result emerges L edges after it is sampled
    always @(posedge clk) begin
      case (alu_opcode[g])
        4'd1: ra <= alu_data_in[g];
        4'd2: acc <= acc + ra;
        4'd3: acc <= acc - ra;
        4'd4: acc <= acc & ra;
        4'd5: acc <= acc | ra;
        4'd6: acc <= acc ^ ra;
        4'd7: p[0] <= acc;
        4'd8: acc <= 8'h00;
        default: ;
      endcase
      p[1] <= p[0];
      p[2] <= p[1];
    end
    assign alu_data_out[g] = p[L-1];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      default: return a;
    endcase
  endfunction

  task automatic send(input int d, input logic [2:0] op, input logic [7:0] v, input logic last);
    int n = 0;
    while (!cmd_ready[d] && n < 40) begin
      tick();
      n++;
    end
    chk("cmd_ready", 32'(cmd_ready[d]), 1);
    cmd_valid[d] = 1'b1;
    cmd_op[d] = op;
    cmd_operand[d] = v;
    cmd_last[d] = last;
    tick();
    cmd_valid[d] = 1'b0;
    cmd_op[d] = 3'($urandom);
    cmd_operand[d] = 8'($urandom);
    cmd_last[d] = 1'($urandom);
    if (op > 3'd5) begin
      chk("err", 32'(err_illegal[d]), 1);
      chk("ill_op", 32'(alu_opcode[d]), 0);
      chk("ill_din", 32'(alu_data_in[d]), 32'(m_din[d]));
      chk("ill_rdy", 32'(cmd_ready[d]), 1);
      tick();
      chk("err_pulse", 32'(err_illegal[d]), 0);
      chk("ill_op2", 32'(alu_opcode[d]), 0);
    end else if (op == 3'd0) begin
      chk("clr_op", 32'(alu_opcode[d]), 8);
      chk("clr_rdy", 32'(cmd_ready[d]), 0);
      chk("clr_din", 32'(alu_data_in[d]), 32'(m_din[d]));
      m_acc[d] = 8'h00;
      m_cnt[d] = 0;
      tick();
      chk("clr_nop", 32'(alu_opcode[d]), 0);
      chk("clr_rdy2", 32'(cmd_ready[d]), 1);
    end else begin
      chk("load_op", 32'(alu_opcode[d]), 1);
      chk("load_din", 32'(alu_data_in[d]), 32'(v));
      chk("busy", 32'(cmd_ready[d]), 0);
      m_din[d] = v;
      tick();
      chk("exec_op", 32'(alu_opcode[d]), 32'(op) + 1);
      chk("exec_din", 32'(alu_data_in[d]), 32'(v));
      m_acc[d] = f(op, m_acc[d], v);
      if (m_cnt[d] < 255) m_cnt[d]++;
      tick();
      if (!last) begin
        chk("idle_op", 32'(alu_opcode[d]), 0);
        chk("idle_rdy", 32'(cmd_ready[d]), 1);
      end else begin
        chk("out_op", 32'(alu_opcode[d]), 7);
        for (int i = 0; i < lat(d); i++) begin
          tick();
          chk("wait_op", 32'(alu_opcode[d]), 0);
          chk("wait_rv", 32'(result_valid[d]), 0);
        end
        tick();
        m_res[d] = m_acc[d];
        m_rc[d] = m_cnt[d];
        m_cnt[d] = 0;
        chk("rv", 32'(result_valid[d]), 1);
        chk("rdata", 32'(result_data[d]), 32'(m_res[d]));
        chk("rcount", 32'(result_count[d]), 32'(m_rc[d]));
        chk("hold_op", 32'(alu_opcode[d]), 0);
        chk("hold_rdy", 32'(cmd_ready[d]), 0);
      end
    end
  endtask

  task automatic take(input int d, input int stall);
    for (int i = 0; i < stall; i++) begin
      cmd_valid[d] = 1'b1;
      cmd_op[d] = 3'd1;
      tick();
      chk("bp_rv", 32'(result_valid[d]), 1);
      chk("bp_data", 32'(result_data[d]), 32'(m_res[d]));
      chk("bp_cnt", 32'(result_count[d]), 32'(m_rc[d]));
      chk("bp_rdy", 32'(cmd_ready[d]), 0);
      chk("bp_op", 32'(alu_opcode[d]), 0);
    end
    cmd_valid[d] = 1'b0;
    result_ready[d] = 1'b1;
    tick();
    result_ready[d] = 1'b0;
    chk("rel_rv", 32'(result_valid[d]), 0);
    chk("rel_rdy", 32'(cmd_ready[d]), 1);
    chk("rel_op", 32'(alu_opcode[d]), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] op;
    logic       last;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      cmd_valid[d] = 1'b0;
      cmd_op[d] = 3'd0;
      cmd_operand[d] = 8'h00;
      cmd_last[d] = 1'b0;
      result_ready[d] = 1'b0;
      m_acc[d] = 8'h00;
      m_din[d] = 8'h00;
      m_res[d] = 8'h00;
      m_cnt[d] = 0;
      m_rc[d] = 0;
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdy", 32'(cmd_ready[d]), 0);
      chk("rst_op", 32'(alu_opcode[d]), 0);
      chk("rst_din", 32'(alu_data_in[d]), 0);
      chk("rst_rv", 32'(result_valid[d]), 0);
      chk("rst_rd", 32'(result_data[d]), 0);
      chk("rst_rc", 32'(result_count[d]), 0);
      chk("rst_err", 32'(err_illegal[d]), 0);
      rst_n[d] = 1'b1;
    end
    tick();
    chk("rdy_after_rst0", 32'(cmd_ready[0]), 1);
    chk("rdy_after_rst1", 32'(cmd_ready[1]), 1);

    send(0, 3'd0, 8'h00, 1'b0);
    send(0, 3'd1, 8'h0F, 1'b0);
    send(0, 3'd3, 8'hAA, 1'b0);
    send(0, 3'd4, 8'h05, 1'b0);
    send(0, 3'd2, 8'h0F, 1'b1);
    chk("dir_data", 32'(result_data[0]), 32'h00);
    chk("dir_cnt", 32'(result_count[0]), 4);
    take(0, 0);

    send(0, 3'd0, 8'h00, 1'b0);
    send(0, 3'd1, 8'hFF, 1'b0);
    send(0, 3'd1, 8'h02, 1'b1);
    chk("wrap_data", 32'(result_data[0]), 32'h01);
    chk("wrap_cnt", 32'(result_count[0]), 2);
    take(0, 5);

    send(0, 3'd6, 8'h55, 1'b1);
    send(0, 3'd7, 8'h66, 1'b0);
    send(0, 3'd1, 8'h10, 1'b1);
    take(0, 1);

    send(0, 3'd1, 8'h21, 1'b0);
    cmd_valid[0] = 1'b1;
    cmd_op[0] = 3'd1;
    cmd_operand[0] = 8'h07;
    cmd_last[0] = 1'b1;
    tick();
    cmd_valid[0] = 1'b0;
    chk("mr_load", 32'(alu_opcode[0]), 1);
    tick();
    chk("mr_exec", 32'(alu_opcode[0]), 2);
    rst_n[0] = 1'b0;
    m_acc[0] = f(3'd1, m_acc[0], 8'h07);
    m_cnt[0] = 0;
    m_din[0] = 8'h00;
    tick();
    chk("mr_op", 32'(alu_opcode[0]), 0);
    chk("mr_rv", 32'(result_valid[0]), 0);
    chk("mr_rdy", 32'(cmd_ready[0]), 0);
    chk("mr_din", 32'(alu_data_in[0]), 0);
    rst_n[0] = 1'b1;
    tick();
    chk("mr_rdy_rel", 32'(cmd_ready[0]), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_no_out", 32'(alu_opcode[0]), 0);
    end

    send(0, 3'd0, 8'h00, 1'b0);
    send(0, 3'd1, 8'h3C, 1'b0);
    result_ready[0] = 1'b1;
    send(0, 3'd5, 8'hF0, 1'b1);
    tick();
    result_ready[0] = 1'b0;
    chk("early_rv", 32'(result_valid[0]), 0);
    chk("early_rdy", 32'(cmd_ready[0]), 1);

    send(0, 3'd0, 8'h00, 1'b0);
    for (int i = 0; i < 256; i++) send(0, 3'd1, 8'h01, 1'b0);
    send(0, 3'd1, 8'h01, 1'b1);
    chk("sat_cnt", 32'(result_count[0]), 255);
    chk("sat_data", 32'(result_data[0]), 32'h01);
    take(0, 0);

    send(0, 3'd0, 8'h00, 1'b0);
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      last = ($urandom_range(0, 3) == 0);
      send(0, op, 8'($urandom), last);
      if (last && op >= 3'd1 && op <= 3'd5) take(0, $urandom_range(0, 3));
    end

    send(1, 3'd0, 8'h00, 1'b0);
    send(1, 3'd1, 8'h33, 1'b0);
    send(1, 3'd5, 8'h0F, 1'b1);
    chk("lat3_data", 32'(result_data[1]), 32'h3C);
    chk("lat3_cnt", 32'(result_count[1]), 2);
    take(1, 2);
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      last = ($urandom_range(0, 2) == 0);
      send(1, op, 8'($urandom), last);
      if (last && op >= 3'd1 && op <= 3'd5) take(1, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
